// File: rtl/router_dist_ctrl_if.sv
// Bus bundle for router_dist_ctrl: input FIFO pop side and per-client push side.
interface router_dist_ctrl_if #(
    parameter int unsigned CLIENTS = 2,
    parameter int unsigned WIDTH   = 32
);
    logic                       empty;
    logic                       pop;
    logic [WIDTH-1:0]           data_in;
    logic [CLIENTS-1:0]         full;
    logic [CLIENTS-1:0]         push;
    logic [CLIENTS*WIDTH-1:0]   data_out;

    // Controller side.
    modport master (
        input  empty,
        output pop,
        input  data_in,
        input  full,
        output push,
        output data_out
    );

    // FIFO / environment side.
    modport slave (
        output empty,
        input  pop,
        output data_in,
        output full,
        input  push,
        input  data_out
    );
endinterface

// File: rtl/router_dist_ctrl.sv
// Distribution controller: pops words from one input FIFO, absorbs the pop-to-data
// latency in a skid buffer and pushes each word to the output FIFO named by its
// destination field. In-order, head-of-line blocking; bad destinations are dropped.
module router_dist_ctrl #(
    parameter int unsigned CLIENTS  = 2,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DELAY    = 1,
    parameter int unsigned DEST_LSB = 0,
    parameter int unsigned DEST_W   = 1,
    parameter int unsigned SKID     = DELAY + 1,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    router_dist_ctrl_if.master      bus,
    output logic [CNT_W-1:0]        drop_count,
    output logic                    busy
);

    localparam int unsigned PTR_W  = (SKID > 1) ? $clog2(SKID) : 1;
    localparam int unsigned SCNT_W = $clog2(SKID + 1);
    // Wide enough for skid count plus every delay stage.
    localparam int unsigned OCC_W  = $clog2(SKID + DELAY + 1);
    localparam logic [CNT_W-1:0] DROP_MAX = '1;

    // Delay chain of pop: stage i holds pop from i clocks ago.
    logic [DELAY:1]         stg_q, stg_d;

    // Skid buffer.
    logic [WIDTH-1:0]       mem_q [SKID];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [SCNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]       drop_q, drop_d;

    logic                   pop;
    logic                   wr_en;
    logic                   head_valid;
    logic [WIDTH-1:0]       head;
    logic [DEST_W-1:0]      dest;
    logic                   dest_ok;
    logic                   dest_full;
    logic                   disp;
    logic                   drop;
    logic [CLIENTS-1:0]     push_vec;
    logic [CLIENTS*WIDTH-1:0] data_vec;
    logic [OCC_W-1:0]       occ;
    logic [OCC_W-1:0]       occ_left;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID - 1)) ? '0 : p + 1'b1;
    endfunction

    // Outputs are forced quiet while reset is held, even before the state clears.
    assign head_valid = !reset && (count_q != '0);
    assign head       = mem_q[rd_ptr_q];
    assign dest       = head[DEST_LSB +: DEST_W];
    assign wr_en      = stg_q[DELAY];

    // Decode head destination, pick the push lane and decide whether the head leaves.
    always_comb begin
        dest_ok   = 1'b0;
        dest_full = 1'b0;
        push_vec  = '0;
        data_vec  = '0;
        for (int c = 0; c < CLIENTS; c++) begin
            if (dest == DEST_W'(c)) begin
                dest_ok     = 1'b1;
                dest_full   = bus.full[c];
                push_vec[c] = head_valid && !bus.full[c];
            end
            data_vec[c*WIDTH +: WIDTH] = head_valid ? head : '0;
        end
        disp = head_valid && (!dest_ok || !dest_full);
        drop = head_valid && !dest_ok;
    end

    // Occupancy and pop: only pop when the word is guaranteed a skid slot on arrival.
    always_comb begin
        occ = OCC_W'(count_q);
        for (int i = 1; i <= DELAY; i++) begin
            occ = occ + OCC_W'(stg_q[i]);
        end
        occ_left = occ - OCC_W'(disp);
        pop      = !reset && !bus.empty && (occ_left < OCC_W'(SKID));
    end

    // Next-state for delay chain, skid pointers/count and drop counter.
    always_comb begin
        stg_d    = stg_q;
        stg_d[1] = pop;
        for (int i = 2; i <= DELAY; i++) begin
            stg_d[i] = stg_q[i-1];
        end

        wr_ptr_d = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = disp  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        count_d = count_q;
        unique case ({wr_en, disp})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        drop_d = drop_q;
        if (drop && (drop_q != DROP_MAX)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stg_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            stg_q    <= stg_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Skid storage; contents are only meaningful below count, so no reset needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    assign bus.pop      = pop;
    assign bus.push     = push_vec;
    assign bus.data_out = data_vec;
    assign drop_count   = drop_q;
    assign busy         = !reset && (occ != '0);

endmodule

// File: tb/tb_router_dist_ctrl.sv
// Bench for router_dist_ctrl: emulates the input FIFO and checks every cycle against
// a transaction-level model (queue of popped words with arrival times).
module tb_router_dist_ctrl;

    localparam int unsigned CLIENTS  = 3;
    localparam int unsigned WIDTH    = 32;
    localparam int unsigned DELAY    = 2;
    localparam int unsigned DEST_LSB = 0;
    localparam int unsigned DEST_W   = 2;
    localparam int unsigned SKID     = DELAY + 1;
    localparam int unsigned CNT_W    = 8;
    localparam int          MAXD     = (1 << CNT_W) - 1;

    typedef struct {
        logic [WIDTH-1:0] word;
        int               avail;
    } entry_t;

    logic               clk = 1'b0;
    logic               reset;
    logic [CNT_W-1:0]   drop_count;
    logic               busy;

    router_dist_ctrl_if #(.CLIENTS(CLIENTS), .WIDTH(WIDTH)) bus ();

    router_dist_ctrl #(
        .CLIENTS  (CLIENTS),
        .WIDTH    (WIDTH),
        .DELAY    (DELAY),
        .DEST_LSB (DEST_LSB),
        .DEST_W   (DEST_W),
        .SKID     (SKID),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .drop_count (drop_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Input FIFO emulation: words waiting, and the pop-to-data pipeline.
    logic [WIDTH-1:0]   src [$];
    logic [WIDTH-1:0]   pipe [1:DELAY];
    assign bus.data_in = pipe[DELAY];

    // Model: every popped word in pop order with the cycle it becomes dispatchable.
    entry_t             mq [$];
    int                 cyc;
    int                 drops;
    int                 checks;
    int                 errors;
    logic               p_rst, p_pop, p_disp, p_bad;

    task automatic chk(input string tag, input logic [CLIENTS*WIDTH-1:0] obs,
                       input logic [CLIENTS*WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] mk(input int dest);
        logic [WIDTH-1:0] w;
        w = $urandom;
        w[DEST_LSB +: DEST_W] = dest[DEST_W-1:0];
        return w;
    endfunction

    // One clock: apply the previous edge to env+model, drive inputs, compare outputs.
    task automatic step(input logic rst_v, input logic [CLIENTS-1:0] full_v, input logic hold);
        logic [WIDTH-1:0]         w;
        logic                     head_ok;
        int                       dest;
        int                       sz;
        logic [CLIENTS-1:0]       e_push;
        logic [CLIENTS*WIDTH-1:0] e_data;
        logic                     e_pop, e_busy, e_disp, e_bad;

        @(negedge clk);
        w = $urandom;
        if (p_pop) w = src.pop_front();
        for (int i = DELAY; i >= 2; i--) pipe[i] = pipe[i-1];
        pipe[1] = w;
        if (p_rst) begin
            mq.delete();
            drops = 0;
        end else begin
            if (p_disp) begin
                void'(mq.pop_front());
                if (p_bad && drops < MAXD) drops++;
            end
            if (p_pop) mq.push_back('{word: w, avail: cyc + DELAY + 1});
        end
        cyc++;

        reset     = rst_v;
        bus.full  = full_v;
        bus.empty = (src.size() == 0) || hold;
        #1;

        e_push  = '0;
        e_data  = '0;
        e_disp  = 1'b0;
        e_bad   = 1'b0;
        head_ok = !rst_v && (mq.size() > 0) && (mq[0].avail <= cyc);
        if (head_ok) begin
            dest = int'(mq[0].word[DEST_LSB +: DEST_W]);
            for (int c = 0; c < CLIENTS; c++) e_data[c*WIDTH +: WIDTH] = mq[0].word;
            if (dest >= CLIENTS) begin
                e_disp = 1'b1;
                e_bad  = 1'b1;
            end else if (!full_v[dest]) begin
                e_disp       = 1'b1;
                e_push[dest] = 1'b1;
            end
        end
        sz     = mq.size();
        e_pop  = !rst_v && !bus.empty && ((sz - int'(e_disp)) < SKID);
        e_busy = !rst_v && (sz != 0);

        chk("pop", bus.pop, e_pop);
        chk("push", bus.push, e_push);
        chk("data_out", bus.data_out, e_data);
        chk("busy", busy, e_busy);
        if (!rst_v) chk("drop_count", drop_count, drops);

        p_rst  = rst_v;
        p_pop  = e_pop;
        p_disp = e_disp;
        p_bad  = e_bad;
    endtask

    initial begin
        logic [CLIENTS-1:0] f;
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        drops     = 0;
        p_rst     = 1'b0;
        p_pop     = 1'b0;
        p_disp    = 1'b0;
        p_bad     = 1'b0;
        reset     = 1'b1;
        bus.full  = '0;
        bus.empty = 1'b1;
        for (int i = 1; i <= DELAY; i++) pipe[i] = '0;

        // Reset state.
        step(1'b1, '0, 1'b0);
        step(1'b1, '0, 1'b0);
        step(1'b0, '0, 1'b0);

        // Single word to client 1.
        src.push_back(32'h0000_0101);
        repeat (6) step(1'b0, '0, 1'b0);

        // Eight words alternating destinations, free-flowing.
        for (int i = 0; i < 8; i++) src.push_back(mk(i % 2));
        repeat (14) step(1'b0, '0, 1'b0);
        chk("idle_busy", busy, 1'b0);

        // Head-of-line blocking on client 0, then release.
        for (int i = 0; i < 5; i++) src.push_back(mk(0));
        repeat (10) step(1'b0, 3'b001, 1'b0);
        repeat (10) step(1'b0, '0, 1'b0);

        // Bad destination dropped, next word delivered.
        src.push_back(mk(3));
        src.push_back(mk(2));
        repeat (6) step(1'b0, '0, 1'b0);

        // Drop counter saturation.
        for (int i = 0; i < 300; i++) src.push_back(mk(3));
        repeat (310) step(1'b0, '0, 1'b0);
        chk("drop_sat", drop_count, 8'd255);

        // Reset mid-stream with words in flight.
        for (int i = 0; i < 4; i++) src.push_back(mk(i % 3));
        repeat (2) step(1'b0, '0, 1'b0);
        step(1'b1, '0, 1'b0);
        repeat (12) step(1'b0, '0, 1'b0);

        // Random traffic with backpressure, input gaps and occasional reset.
        repeat (400) begin
            if (src.size() < 4) src.push_back(mk($urandom_range(0, 3)));
            for (int c = 0; c < CLIENTS; c++) f[c] = ($urandom_range(0, 3) == 0);
            step(($urandom_range(0, 99) == 0), f, ($urandom_range(0, 3) == 0));
        end

        // Drain.
        repeat (30) step(1'b0, '0, 1'b0);
        chk("final_busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
